// File: rtl/io_key_capture.sv
// Memory-mapped pushbutton/switch input block: synchronise, debounce, sticky press capture with W1C.
// Optional feature macro KEY_IRQ_EN adds a key mask register at 0x180 and a registered irq output.
module io_key_capture #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NKEYS           = 4,
    parameter int NSW             = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] key_n,
    input  logic [NSW-1:0]   sw,
    input  logic [31:0]      addr,
    input  logic             memwrite,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata
`ifdef KEY_IRQ_EN
    ,
    output logic             irq
`endif
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NKEYS-1:0]          ksync1_q, ksync_q;
    logic [NSW-1:0]            swsync1_q, sw_sync_q;
    logic [NKEYS-1:0]          key_db_q, key_db_d;
    logic [NKEYS-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [NKEYS-1:0]          cap_q, cap_d;
    logic [NKEYS-1:0]          press;
    logic [NKEYS-1:0]          clr_mask;
    logic                      io_sel;

    assign io_sel = addr[8];

    // Each key only flips once it has disagreed with its debounced value for DEBOUNCE_CYCLES edges in a row.
    generate
        for (genvar gi = 0; gi < NKEYS; gi++) begin : g_debounce
            logic differ_w;
            logic at_last_w;
            assign differ_w     = ksync_q[gi] != key_db_q[gi];
            assign at_last_w    = cnt_q[gi] == CNT_LAST;
            assign key_db_d[gi] = (differ_w && at_last_w) ? ksync_q[gi] : key_db_q[gi];
            assign cnt_d[gi]    = (!differ_w || at_last_w) ? '0 : cnt_q[gi] + CW'(1);
        end
    endgenerate

    // A press sets its cap bit even when the same bit is being cleared this cycle.
    assign press    = key_db_q & ~key_db_d;
    assign clr_mask = (memwrite && io_sel && addr[6]) ? writedata[NKEYS-1:0] : '0;
    assign cap_d    = (cap_q & ~clr_mask) | press;

    always_ff @(posedge clk) begin
        if (reset) begin
            ksync1_q  <= '1;
            ksync_q   <= '1;
            swsync1_q <= '0;
            sw_sync_q <= '0;
            key_db_q  <= '1;
            cnt_q     <= '0;
            cap_q     <= '0;
        end else begin
            ksync1_q  <= key_n;
            ksync_q   <= ksync1_q;
            swsync1_q <= sw;
            sw_sync_q <= swsync1_q;
            key_db_q  <= key_db_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
        end
    end

`ifdef KEY_IRQ_EN
    logic [NKEYS-1:0] mask_q, mask_d;
    logic             irq_q, irq_d;

    assign mask_d = (memwrite && io_sel && addr[7]) ? writedata[NKEYS-1:0] : mask_q;
    assign irq_d  = |(cap_q & mask_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        readdata = '0;
        if (io_sel) begin
            if (addr[4]) begin
                readdata = 32'(key_db_q);
            end else if (addr[5]) begin
                readdata = 32'(sw_sync_q);
            end else if (addr[6]) begin
                readdata = 32'(cap_q);
`ifdef KEY_IRQ_EN
            end else if (addr[7]) begin
                readdata = 32'(mask_q);
`endif
            end
        end
    end

`ifdef KEY_IRQ_EN
    logic unused_bits;
    assign unused_bits = ^{addr[31:9], addr[3:0], writedata[31:NKEYS]};
`else
    logic unused_bits;
    assign unused_bits = ^{addr[31:9], addr[7], addr[3:0], writedata[31:NKEYS]};
`endif
endmodule
